// File: rtl/mux_rr_scheduler.sv
// mux_rr_scheduler: round-robin owner scheduler for an 8-way shared mux.
//
// Picks one of eight requesters and holds it as mux owner until one of these happens:
// - the owner signals done,
// - the owner drops its request,
// - the owner reaches the HOLD_MAX cycle limit.
// Each grant is followed by a one-cycle GAP (break-before-make) and then an IDLE cycle,
// so two grants are always separated by two cycles with En low.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   req      [7:0] request vector, bit i = requester i
//   done     owner release, only looked at while serving
//   s        [2:0] registered mux select (binary index of owner)
//   En       registered mux enable, high only while serving
//   gnt      [7:0] registered one-hot grant, (1 << s) while serving, else 0
//   busy     registered, high while serving or in the turnaround gap
//   timeout  registered one-cycle pulse when a grant is revoked by the hold limit
module mux_rr_scheduler #(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [2:0] s,
  output logic       En,
  output logic [7:0] gnt,
  output logic       busy,
  output logic       timeout
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StServe = 2'd1;
  localparam logic [1:0] StGap   = 2'd2;

  localparam logic [7:0] HoldLast = 8'(HOLD_MAX - 1);

  logic [1:0] state_q, state_d;
  logic [2:0] s_q, s_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] hold_q, hold_d;
  logic       en_q, en_d;
  logic [7:0] gnt_q, gnt_d;
  logic       busy_q, busy_d;
  logic       timeout_q, timeout_d;

  // Round-robin search starting just after the last owner; offset 8 wraps back to ptr
  // itself, so the last owner is considered only when nobody else is requesting.
  logic [2:0] win;
  logic [2:0] idx;
  logic       found;

  always_comb begin
    win   = 3'd0;
    idx   = 3'd0;
    found = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      idx = ptr_q + 3'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  logic rel_done;
  logic rel_drop;
  logic rel_limit;

  assign rel_done  = done;
  assign rel_drop  = ~req[s_q];
  assign rel_limit = (hold_q == HoldLast);

  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    en_d      = 1'b0;
    gnt_d     = 8'd0;
    busy_d    = 1'b0;
    timeout_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (found) begin
          state_d = StServe;
          s_d     = win;
          ptr_d   = win;
          hold_d  = 8'd0;
          en_d    = 1'b1;
          gnt_d   = 8'd1 << win;
          busy_d  = 1'b1;
        end
      end

      StServe: begin
        if (rel_done || rel_drop || rel_limit) begin
          state_d = StGap;
          busy_d  = 1'b1;
          // Only a pure hold-limit release counts as a timeout.
          timeout_d = rel_limit && !rel_done && !rel_drop;
        end else begin
          en_d   = 1'b1;
          gnt_d  = gnt_q;
          busy_d = 1'b1;
          if (hold_q != 8'hFF) begin
            hold_d = hold_q + 8'd1;
          end
        end
      end

      StGap: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      s_q       <= 3'd0;
      ptr_q     <= 3'd7;
      hold_q    <= 8'd0;
      en_q      <= 1'b0;
      gnt_q     <= 8'd0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      en_q      <= en_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign s       = s_q;
  assign En      = en_q;
  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: doc/mux_rr_scheduler.md
MUX_RR_SCHEDULER -- requirements
Module: mux_rr_scheduler

Interface
REQ-001 Parameter HOLD_MAX, default 16, meaning maximum consecutive SERVE cycles per grant; legal range 1..255.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 req  input  8  request vector; bit i = requester i wants the shared mux.
REQ-005 done  input  1  the current owner signals release; sampled only in SERVE.
REQ-006 s  output  3  mux select; binary index of the granted requester.
REQ-007 En  output  1  mux enable; high only in SERVE.
REQ-008 gnt  output  8  one-hot grant; equals (1 << s) in SERVE, otherwise 0.
REQ-009 busy  output  1  high in SERVE and GAP.
REQ-010 timeout  output  1  one-cycle pulse when a grant is revoked by the HOLD_MAX limit.
REQ-011 All outputs SHALL be registered; no combinational path from inputs to outputs.

Function
REQ-012 The FSM SHALL have exactly 3 states: IDLE, SERVE and GAP.
REQ-013 IDLE: En=0 and gnt=0; if req!=0 at a clock edge, the next state SHALL be SERVE with s equal to the arbitration winner.
REQ-014 IDLE with req==0 SHALL remain in IDLE, with s holding its last value.
REQ-015 The arbitration winner SHALL be the first set bit of req searched upward from index (ptr+1) mod 8, wrapping 7->0, where ptr is the last granted index.
REQ-016 ptr SHALL update to the winner index on entry to SERVE.
REQ-017 Grant latency SHALL be exactly 1 cycle: req sampled at edge N gives En=1 and gnt valid after edge N.
REQ-018 SERVE SHALL hold s, gnt and En=1 stable until release.
REQ-019 In SERVE, a hold counter SHALL start at 0 on entry and increment each SERVE cycle; the counter is 8 bits wide and never wraps.
REQ-020 SERVE SHALL release to GAP on the first edge at which any of the following is true: done=1; req[s]=0; or hold counter == HOLD_MAX-1.
REQ-021 timeout SHALL pulse for one cycle on the GAP entry only when the release cause is the HOLD_MAX limit and neither done=1 nor req[s]=0.
REQ-022 When causes coincide, done or request-drop SHALL take priority, and timeout SHALL stay 0.
REQ-023 GAP SHALL last exactly 1 cycle with En=0 and gnt=0 (a break-before-make turnaround), then go to IDLE.
REQ-024 Minimum spacing between two grants SHALL therefore be 2 cycles with En low.
REQ-025 A SERVE lasting the full HOLD_MAX limit SHALL keep En high for exactly HOLD_MAX cycles.
REQ-026 The requester just served SHALL have lowest priority in the next arbitration; with a single requester active, it SHALL be re-granted after GAP+IDLE.
REQ-027 req changes on bits other than s during SERVE SHALL be ignored.
REQ-028 done asserted in IDLE or GAP SHALL be ignored.

Reset
REQ-029 On rst=1 at a clock edge: state=IDLE, s=0, En=0, gnt=0, busy=0, timeout=0, hold counter=0, ptr=7 (so index 0 has first priority).
REQ-030 rst SHALL override every state, including mid-SERVE; outputs SHALL be at reset values after that edge.
REQ-031 The first arbitration after rst deasserts SHALL follow REQ-013, regardless of any req held during reset.

Verification
REQ-032 Reset then req=8'b0000_0100 held, done=0, HOLD_MAX=16 -> one cycle later: s=2, En=1, gnt=8'h04, busy=1.
REQ-033 Round robin: req=8'hFF held, done pulsed 1 cycle after each grant -> s sequence 0,1,2,...,7,0 with exactly 2 En-low cycles between grants.
REQ-034 Timeout: req=8'h01 held, done=0, HOLD_MAX=4 -> En high exactly 4 cycles; timeout=1 on the GAP cycle; re-grant to s=0 after GAP+IDLE.
REQ-035 Coincident release: HOLD_MAX=4 with done=1 on the 4th SERVE cycle -> release to GAP with timeout=0.
REQ-036 Request drop: grant to s=5 (req=8'h20), then req[5]->0 mid-SERVE -> GAP on the next edge, En=0 and gnt=0.
REQ-037 Reset mid-SERVE: rst=1 while s=3 and En=1 -> next edge: En=0, gnt=0, s=0; with req=8'h88 after release, first grant goes to s=3.
